lane_renderer: RTL and testbench

Parametrised pixel generator for the unit lane of the battle screen. It takes a flattened array of unit locations and types from the game logic and maps each scan position (hCount/vCount) to a 12-bit RGB value. Unit state is double-buffered: a request/acknowledge handshake captures a snapshot into a shadow bank, and that bank is committed to the display bank only at a frame boundary, so a frame never tears. It sits between the game-state core and the VGA display controller.

---
 rtl/lane_renderer_if.sv | 28 ++
 rtl/lane_renderer.sv | 174 +++++++++++++++++
 tb/tb_lane_renderer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_renderer_if.sv
// Scan, unit-state and pixel signals between the game core / VGA controller and lane_renderer.
interface lane_renderer_if #(
  parameter int NUM_UNITS = 16,
  parameter int LOC_W     = 9,
  parameter int TYPE_W    = 2
);
  localparam int CNT_W = $clog2(NUM_UNITS + 1);

  logic                        bright;
  logic [9:0]                  hCount;
  logic [9:0]                  vCount;
  logic                        update_req;
  logic [NUM_UNITS*LOC_W-1:0]  unit_loc_flat;
  logic [NUM_UNITS*TYPE_W-1:0] unit_type_flat;
  logic                        update_ack;
  logic [CNT_W-1:0]            units_alive;
  logic [11:0]                 rgb;

  modport master (
    output bright, hCount, vCount, update_req, unit_loc_flat, unit_type_flat,
    input  update_ack, units_alive, rgb
  );

  modport slave (
    input  bright, hCount, vCount, update_req, unit_loc_flat, unit_type_flat,
    output update_ack, units_alive, rgb
  );
endinterface

// File: rtl/lane_renderer.sv
// Lane pixel generator with double-buffered unit state committed at frame boundaries.
// Optional build macro: LANE_RENDERER_OUTLINE_EN draws a black 1-pixel outline on sprites.

// Per-slot horizontal hit test; sums are 11 bits so loc+offset never wraps.
module lane_slot #(
  parameter int LOC_W    = 9,
  parameter int TYPE_W   = 2,
  parameter int H_OFFSET = 203,
  parameter int UNIT_W   = 10
) (
  input  logic [LOC_W-1:0]  loc,
  input  logic [TYPE_W-1:0] typ,
  input  logic [9:0]        hcount,
  output logic              hit,
  output logic              outl
);
  logic [10:0] left, right, h;
  assign left  = 11'(loc) + 11'(H_OFFSET);
  assign right = left + 11'(UNIT_W - 1);
  assign h     = {1'b0, hcount};
  assign hit   = (typ != '0) && (h >= left) && (h <= right);
`ifdef LANE_RENDERER_OUTLINE_EN
  assign outl  = (h == left) || (h == right);
`else
  assign outl  = 1'b0;
`endif
endmodule

module lane_renderer #(
  parameter int          NUM_UNITS    = 16,
  parameter int          LOC_W        = 9,
  parameter int          TYPE_W       = 2,
  parameter int          H_OFFSET     = 203,
  parameter int          UNIT_W       = 10,
  parameter int          LANE_TOP     = 386,
  parameter int          LANE_BOT     = 395,
  parameter int          GROUND_ROW   = 396,
  parameter logic [11:0] SKY_COLOR    = 12'h37B,
  parameter logic [11:0] GROUND_COLOR = 12'h2D2,
  parameter logic [11:0] TYPE1_COLOR  = 12'hF00,
  parameter logic [11:0] TYPE2_COLOR  = 12'h0F0,
  parameter logic [11:0] TYPE3_COLOR  = 12'h00F
) (
  input logic            clk,
  input logic            rst,
  lane_renderer_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_UNITS + 1);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  localparam logic [9:0] V_TOP = 10'(LANE_TOP);
  localparam logic [9:0] V_BOT = 10'(LANE_BOT);
  localparam logic [9:0] V_GND = 10'(GROUND_ROW);

  logic [NUM_UNITS-1:0][LOC_W-1:0]  shd_loc, dsp_loc;
  logic [NUM_UNITS-1:0][TYPE_W-1:0] shd_type, dsp_type;
  logic [0:0]       state;
  logic             zero_q, scan_zero, fb;
  logic [CNT_W-1:0] shd_alive;

  assign scan_zero = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);
  // zero_q resets to 1 so a scan already at (0,0) out of reset is not a boundary
  assign fb = scan_zero && !zero_q;

  // Population of the shadow bank; registered at commit it equals the new display count
  always_comb begin
    shd_alive = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (shd_type[i] != '0) shd_alive = shd_alive + CNT_W'(1);
  end

  // Shadow capture, update FSM and frame-boundary commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      zero_q          <= 1'b1;
      shd_loc         <= '0;
      shd_type        <= '0;
      dsp_loc         <= '0;
      dsp_type        <= '0;
      bus.update_ack  <= 1'b0;
      bus.units_alive <= '0;
    end else begin
      zero_q         <= scan_zero;
      bus.update_ack <= 1'b0;
      if (bus.update_req) begin
        shd_loc  <= bus.unit_loc_flat;
        shd_type <= bus.unit_type_flat;
      end
      case (state)
        IDLE:    if (bus.update_req) state <= PENDING;
        PENDING: if (fb) begin
          // commit sees the pre-request shadow; a coincident request waits for the next fb
          dsp_loc         <= shd_loc;
          dsp_type        <= shd_type;
          bus.update_ack  <= 1'b1;
          bus.units_alive <= shd_alive;
          state           <= bus.update_req ? PENDING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_UNITS-1:0] slot_hit, slot_outl;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slot
    lane_slot #(.LOC_W(LOC_W), .TYPE_W(TYPE_W), .H_OFFSET(H_OFFSET), .UNIT_W(UNIT_W)) u_slot (
      .loc    (dsp_loc[g]),
      .typ    (dsp_type[g]),
      .hcount (bus.hCount),
      .hit    (slot_hit[g]),
      .outl   (slot_outl[g])
    );
  end

  logic              sel_hit, sel_outl, lane, row_edge;
  logic [TYPE_W-1:0] sel_type;

  assign lane = (bus.vCount >= V_TOP) && (bus.vCount <= V_BOT);
`ifdef LANE_RENDERER_OUTLINE_EN
  assign row_edge = (bus.vCount == V_TOP) || (bus.vCount == V_BOT);
`else
  assign row_edge = 1'b0;
`endif

  // Priority encoder: scan downwards so the lowest hitting slot wins
  always_comb begin
    sel_hit  = 1'b0;
    sel_outl = 1'b0;
    sel_type = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (slot_hit[i]) begin
        sel_hit  = 1'b1;
        sel_type = dsp_type[i];
        sel_outl = slot_outl[i];
      end
  end

  logic              hit_q, bright_q, gnd_q, outl_q;
  logic [TYPE_W-1:0] type_q;

  // Pixel stage 1: register hit, type, outline, bright and background select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q    <= 1'b0;
      type_q   <= '0;
      outl_q   <= 1'b0;
      bright_q <= 1'b0;
      gnd_q    <= 1'b0;
    end else begin
      hit_q    <= lane && sel_hit;
      type_q   <= sel_type;
      outl_q   <= sel_outl || row_edge;
      bright_q <= bus.bright;
      gnd_q    <= bus.vCount >= V_GND;
    end
  end

  // Pixel stage 2: blanking, sprite color (or outline), else ground/sky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                bus.rgb <= 12'h000;
    else if (!bright_q)      bus.rgb <= 12'h000;
    else if (hit_q) begin
      if (outl_q)                       bus.rgb <= 12'h000;
      else if (type_q == TYPE_W'(1))    bus.rgb <= TYPE1_COLOR;
      else if (type_q == TYPE_W'(2))    bus.rgb <= TYPE2_COLOR;
      else if (type_q == TYPE_W'(3))    bus.rgb <= TYPE3_COLOR;
      else                              bus.rgb <= 12'h000;
    end
    else if (gnd_q)          bus.rgb <= GROUND_COLOR;
    else                     bus.rgb <= SKY_COLOR;
  end
endmodule

// File: tb/tb_lane_renderer.sv
// Directed self-checking bench for lane_renderer (honours LANE_RENDERER_OUTLINE_EN).
module tb_lane_renderer;
  localparam int N = 16, LW = 9, TW = 2;
`ifdef LANE_RENDERER_OUTLINE_EN
  localparam bit OUTL = 1'b1;
`else
  localparam bit OUTL = 1'b0;
`endif
  localparam logic [11:0] SKY = 12'h37B, GND = 12'h2D2;

  logic clk = 1'b0, rst = 1'b0;
  int   n_chk = 0, n_fail = 0;
  logic [N*LW-1:0] locs;
  logic [N*TW-1:0] types;
  logic [3:0]      acks;
  logic [11:0]     e;

  always #5 clk = ~clk;

  lane_renderer_if #(.NUM_UNITS(N), .LOC_W(LW), .TYPE_W(TW)) bus ();
  lane_renderer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic set_slot(input int i, input int loc, input int typ);
    locs[i*LW +: LW]  = LW'(loc);
    types[i*TW +: TW] = TW'(typ);
  endtask

  // drive a scan position and wait out the 2-cycle pixel latency
  task automatic pix(input int h, input int v, input logic b);
    bus.hCount = 10'(h); bus.vCount = 10'(v); bus.bright = b;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic req_pulse();
    bus.unit_loc_flat = locs; bus.unit_type_flat = types; bus.update_req = 1'b1;
    @(negedge clk);
    bus.update_req = 1'b0;
  endtask

  // dwell 3 cycles at (0,0), optionally with a request on the fb cycle; acks[k] = ack at k-th negedge
  task automatic run_fb(input logic with_req, output logic [3:0] a);
    bus.hCount = 10'd0; bus.vCount = 10'd0;
    if (with_req) begin
      bus.unit_loc_flat = locs; bus.unit_type_flat = types; bus.update_req = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a[k] = bus.update_ack;
      if (k == 0) bus.update_req = 1'b0;
      if (k == 2) begin bus.hCount = 10'd5; bus.vCount = 10'd5; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pix(217, 390, 1'b1); @(negedge clk);
    n_chk++; if (bus.rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got=%h exp=000", bus.rgb); end
    n_chk++; if (bus.update_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", bus.update_ack); end
    n_chk++; if (bus.units_alive !== 5'd0) begin n_fail++; $display("FAIL reset_alive got=%0d exp=0", bus.units_alive); end
    rst = 1'b1;
    pix(217, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL post_reset_sky got=%h exp=%h", bus.rgb, SKY); end
    pix(217, 395, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL post_reset_v395 got=%h exp=%h", bus.rgb, SKY); end
    pix(217, 396, 1'b1);
    n_chk++; if (bus.rgb !== GND) begin n_fail++; $display("FAIL post_reset_v396 got=%h exp=%h", bus.rgb, GND); end
  endtask

  task automatic test_single_unit();
    locs = '0; types = '0; set_slot(0, 10, 1);
    pix(100, 100, 1'b1);
    req_pulse();
    run_fb(1'b0, acks);
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", acks); end
    n_chk++; if (bus.units_alive !== 5'd1) begin n_fail++; $display("FAIL single_alive got=%0d exp=1", bus.units_alive); end
    e = OUTL ? 12'h000 : 12'hF00;
    pix(213, 390, 1'b1);
    n_chk++; if (bus.rgb !== e) begin n_fail++; $display("FAIL single_h213 got=%h exp=%h", bus.rgb, e); end
    pix(222, 390, 1'b1);
    n_chk++; if (bus.rgb !== e) begin n_fail++; $display("FAIL single_h222 got=%h exp=%h", bus.rgb, e); end
    pix(217, 390, 1'b1);
    n_chk++; if (bus.rgb !== 12'hF00) begin n_fail++; $display("FAIL single_h217 got=%h exp=F00", bus.rgb); end
    pix(217, 386, 1'b1);
    n_chk++; if (bus.rgb !== e) begin n_fail++; $display("FAIL single_v386 got=%h exp=%h", bus.rgb, e); end
    pix(212, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL single_h212 got=%h exp=%h", bus.rgb, SKY); end
    pix(223, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL single_h223 got=%h exp=%h", bus.rgb, SKY); end
    pix(217, 385, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL single_v385 got=%h exp=%h", bus.rgb, SKY); end
  endtask

  task automatic test_blanking();
    pix(217, 390, 1'b0);
    n_chk++; if (bus.rgb !== 12'h000) begin n_fail++; $display("FAIL blank_hit got=%h exp=000", bus.rgb); end
    // one-cycle bright gap: the blank pixel must land exactly two cycles later
    bus.hCount = 10'd217; bus.vCount = 10'd390; bus.bright = 1'b1;
    @(negedge clk); bus.bright = 1'b0;
    @(negedge clk); bus.bright = 1'b1;
    n_chk++; if (bus.rgb !== 12'hF00) begin n_fail++; $display("FAIL blank_align_pre got=%h exp=F00", bus.rgb); end
    @(negedge clk);
    n_chk++; if (bus.rgb !== 12'h000) begin n_fail++; $display("FAIL blank_align got=%h exp=000", bus.rgb); end
    @(negedge clk);
  endtask

  task automatic test_overlap();
    locs = '0; types = '0; set_slot(3, 50, 3); set_slot(7, 50, 2);
    req_pulse();
    run_fb(1'b0, acks);
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL overlap_ack got=%b exp=0001", acks); end
    n_chk++; if (bus.units_alive !== 5'd2) begin n_fail++; $display("FAIL overlap_alive got=%0d exp=2", bus.units_alive); end
    pix(257, 390, 1'b1);
    n_chk++; if (bus.rgb !== 12'h00F) begin n_fail++; $display("FAIL overlap_h257 got=%h exp=00F", bus.rgb); end
    e = OUTL ? 12'h000 : 12'h00F;
    pix(253, 390, 1'b1);
    n_chk++; if (bus.rgb !== e) begin n_fail++; $display("FAIL overlap_h253 got=%h exp=%h", bus.rgb, e); end
    pix(262, 390, 1'b1);
    n_chk++; if (bus.rgb !== e) begin n_fail++; $display("FAIL overlap_h262 got=%h exp=%h", bus.rgb, e); end
    pix(263, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL overlap_h263 got=%h exp=%h", bus.rgb, SKY); end
    pix(213, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL overlap_old_gone got=%h exp=%h", bus.rgb, SKY); end
  endtask

  task automatic test_tear_free();
    locs = '0; types = '0; set_slot(0, 100, 2);
    pix(50, 200, 1'b1);
    req_pulse();
    acks = '0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); acks[k] = bus.update_ack; end
    pix(257, 390, 1'b1);
    n_chk++; if (bus.rgb !== 12'h00F) begin n_fail++; $display("FAIL tear_old_kept got=%h exp=00F", bus.rgb); end
    pix(305, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL tear_new_hidden got=%h exp=%h", bus.rgb, SKY); end
    n_chk++; if (acks !== 4'b0000 || bus.update_ack !== 1'b0) begin n_fail++; $display("FAIL tear_early_ack got=%b exp=0000", acks); end
    run_fb(1'b0, acks);
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL tear_ack got=%b exp=0001", acks); end
    pix(305, 390, 1'b1);
    n_chk++; if (bus.rgb !== 12'h0F0) begin n_fail++; $display("FAIL tear_new_shown got=%h exp=0F0", bus.rgb); end
    pix(257, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL tear_old_cleared got=%h exp=%h", bus.rgb, SKY); end
    n_chk++; if (bus.units_alive !== 5'd1) begin n_fail++; $display("FAIL tear_alive got=%0d exp=1", bus.units_alive); end
  endtask

  task automatic test_coalescing();
    locs = '0; types = '0; set_slot(1, 20, 3);                  // A: 223..232
    req_pulse(); @(negedge clk);
    locs = '0; types = '0; set_slot(2, 30, 1);                  // B: 233..242
    req_pulse(); @(negedge clk);
    locs = '0; types = '0; set_slot(4, 60, 2); set_slot(5, 90, 1); // C: 263..272, 293..302
    run_fb(1'b1, acks);
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL coal_ack_b got=%b exp=0001", acks); end
    pix(235, 390, 1'b1);
    n_chk++; if (bus.rgb !== 12'hF00) begin n_fail++; $display("FAIL coal_b_shown got=%h exp=F00", bus.rgb); end
    pix(226, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL coal_a_dropped got=%h exp=%h", bus.rgb, SKY); end
    pix(265, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL coal_c_waits got=%h exp=%h", bus.rgb, SKY); end
    n_chk++; if (bus.units_alive !== 5'd1) begin n_fail++; $display("FAIL coal_alive_b got=%0d exp=1", bus.units_alive); end
    run_fb(1'b0, acks);
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL coal_ack_c got=%b exp=0001", acks); end
    pix(265, 390, 1'b1);
    n_chk++; if (bus.rgb !== 12'h0F0) begin n_fail++; $display("FAIL coal_c_shown got=%h exp=0F0", bus.rgb); end
    pix(235, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL coal_b_cleared got=%h exp=%h", bus.rgb, SKY); end
    n_chk++; if (bus.units_alive !== 5'd2) begin n_fail++; $display("FAIL coal_alive_c got=%0d exp=2", bus.units_alive); end
    run_fb(1'b0, acks);
    n_chk++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL coal_no_extra_ack got=%b exp=0000", acks); end
  endtask

  task automatic test_reset_mid();
    locs = '0; types = '0; set_slot(0, 10, 1);
    pix(100, 100, 1'b1);
    req_pulse();
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    n_chk++; if (bus.units_alive !== 5'd0) begin n_fail++; $display("FAIL rstmid_alive got=%0d exp=0", bus.units_alive); end
    pix(295, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL rstmid_cleared got=%h exp=%h", bus.rgb, SKY); end
    run_fb(1'b0, acks);
    n_chk++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL rstmid_no_ack got=%b exp=0000", acks); end
    pix(217, 390, 1'b1);
    n_chk++; if (bus.rgb !== SKY) begin n_fail++; $display("FAIL rstmid_discarded got=%h exp=%h", bus.rgb, SKY); end
  endtask

  initial begin
    bus.bright = 1'b0; bus.hCount = '0; bus.vCount = '0; bus.update_req = 1'b0;
    bus.unit_loc_flat = '0; bus.unit_type_flat = '0;
    locs = '0; types = '0; acks = '0; e = '0;
    @(negedge clk);
    test_reset();
    test_single_unit();
    test_blanking();
    test_overlap();
    test_tear_free();
    test_coalescing();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
